// File: rtl/riscv_core_dpath_vec_seq_alu.sv
// Element-serial vector ALU: processes one 32-bit element per cycle under vl/mask
// control, then issues a single registered write toward the vector regfile.
module riscv_core_dpath_vec_seq_alu #(
    parameter int NELEM = 8,
    parameter int EW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_val,
    output logic                  req_rdy,
    input  logic [2:0]            req_op,
    input  logic                  req_vs,
    input  logic [4:0]            req_waddr,
    input  logic [3:0]            req_vl,
    input  logic                  req_masken,
    input  logic [NELEM-1:0]      req_mask,
    input  logic [NELEM*EW-1:0]   req_a,
    input  logic [NELEM*EW-1:0]   req_b,
    input  logic [EW-1:0]         req_s,
    input  logic [NELEM*EW-1:0]   req_old,
    output logic                  busy,
    output logic                  wen_p,
    output logic [4:0]            waddr_p,
    output logic [NELEM*EW-1:0]   wvec_p
);

    localparam int IW = $clog2(NELEM);
    localparam int SW = $clog2(EW);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA
    } op_t;
    typedef logic [NELEM-1:0][EW-1:0] vec_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       vlc_q, vlc_d;
    vec_t             result_q, result_d;

    op_t              op_q;
    logic             vs_q, masken_q;
    logic [4:0]       waddr_q;
    logic [NELEM-1:0] mask_q;
    vec_t             a_q, b_q;
    logic [EW-1:0]    s_q;

    logic             wen_q;
    logic [4:0]       wbaddr_q;
    vec_t             wbvec_q;

    logic             accept;
    logic [3:0]       vlClamp;
    logic [EW-1:0]    opA, opB, aluRes;

    assign req_rdy = (state_q == IDLE) || (state_q == WB);
    assign busy    = (state_q != IDLE);
    assign accept  = req_val && req_rdy;
    assign vlClamp = (req_vl > 4'(NELEM)) ? 4'(NELEM) : req_vl;

    assign wen_p   = wen_q;
    assign waddr_p = wbaddr_q;
    assign wvec_p  = wbvec_q;

    always_comb begin
        opA    = a_q[idx_q];
        opB    = vs_q ? s_q : b_q[idx_q];
        aluRes = '0;
        case (op_q)
            OP_ADD:  aluRes = opA + opB;
            OP_SUB:  aluRes = opA - opB;
            OP_AND:  aluRes = opA & opB;
            OP_OR:   aluRes = opA | opB;
            OP_XOR:  aluRes = opA ^ opB;
            OP_SLL:  aluRes = opA << opB[SW-1:0];
            OP_SRL:  aluRes = opA >> opB[SW-1:0];
            OP_SRA:  aluRes = $signed(opA) >>> opB[SW-1:0];
            default: aluRes = '0;
        endcase
    end

    // A new request may land in WB, so the accept path overrides the per-state update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vlc_d    = vlc_q;
        result_d = result_q;
        case (state_q)
            EXEC: begin
                if (!masken_q || mask_q[idx_q]) begin
                    result_d[idx_q] = aluRes;
                end
                idx_d = idx_q + 1'b1;
                if ({1'b0, idx_q} == vlc_q - 4'd1) begin
                    state_d = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = state_q;
        endcase
        if (accept) begin
            vlc_d    = vlClamp;
            idx_d    = '0;
            result_d = req_old;
            state_d  = (vlClamp != 4'd0) ? EXEC : WB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            vlc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vlc_q    <= vlc_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_ADD;
            vs_q     <= 1'b0;
            masken_q <= 1'b0;
            waddr_q  <= '0;
            mask_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
        end else if (accept) begin
            op_q     <= op_t'(req_op);
            vs_q     <= req_vs;
            masken_q <= req_masken;
            waddr_q  <= req_waddr;
            mask_q   <= req_mask;
            a_q      <= req_a;
            b_q      <= req_b;
            s_q      <= req_s;
        end
    end

    // Write port is loaded on entry to WB so wen_p is high exactly while in WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen_q    <= 1'b0;
            wbaddr_q <= '0;
            wbvec_q  <= '0;
        end else begin
            wen_q <= (state_d == WB);
            if (state_d == WB) begin
                wbaddr_q <= accept ? req_waddr : waddr_q;
                wbvec_q  <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_dpath_vec_seq_alu.sv
// Self-checking bench for the element-serial vector ALU: directed cases plus
// randomized requests compared against a plain-arithmetic reference model.
module tb_riscv_core_dpath_vec_seq_alu;

    logic         clk;
    logic         reset;
    logic         req_val;
    logic         req_rdy;
    logic [2:0]   req_op;
    logic         req_vs;
    logic [4:0]   req_waddr;
    logic [3:0]   req_vl;
    logic         req_masken;
    logic [7:0]   req_mask;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [31:0]  req_s;
    logic [255:0] req_old;
    logic         busy;
    logic         wen_p;
    logic [4:0]   waddr_p;
    logic [255:0] wvec_p;

    int checks = 0;
    int errors = 0;

    riscv_core_dpath_vec_seq_alu #(.NELEM(8), .EW(32)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_vs(req_vs),
        .req_waddr(req_waddr), .req_vl(req_vl), .req_masken(req_masken),
        .req_mask(req_mask), .req_a(req_a), .req_b(req_b), .req_s(req_s),
        .req_old(req_old), .busy(busy), .wen_p(wen_p), .waddr_p(waddr_p),
        .wvec_p(wvec_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] splat(input logic [31:0] v);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = v;
        return r;
    endfunction

    // Reference: result starts as old, active unmasked elements get op(a[i], B).
    function automatic logic [255:0] refVec(input int op, input bit vs, input logic [31:0] s,
                                            input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] old, input int vl,
                                            input bit me, input logic [7:0] mk);
        logic [255:0] r;
        logic [31:0]  x, y, z;
        int n;
        r = old;
        n = (vl > 8) ? 8 : vl;
        for (int i = 0; i < n; i++) begin
            if (!me || mk[i]) begin
                x = a[32*i +: 32];
                y = vs ? s : b[32*i +: 32];
                case (op)
                    0: z = x + y;
                    1: z = x - y;
                    2: z = x & y;
                    3: z = x | y;
                    4: z = x ^ y;
                    5: z = x << y[4:0];
                    6: z = x >> y[4:0];
                    default: z = $unsigned($signed(x) >>> y[4:0]);
                endcase
                r[32*i +: 32] = z;
            end
        end
        return r;
    endfunction

    task automatic setFields(input logic [2:0] op, input bit vs, input logic [4:0] wa,
                             input logic [3:0] vl, input bit me, input logic [7:0] mk,
                             input logic [255:0] a, input logic [255:0] b,
                             input logic [31:0] s, input logic [255:0] old);
        req_op = op; req_vs = vs; req_waddr = wa; req_vl = vl;
        req_masken = me; req_mask = mk; req_a = a; req_b = b; req_s = s; req_old = old;
    endtask

    task automatic scrambleFields();
        req_op = 3'($urandom); req_vs = 1'($urandom); req_waddr = 5'($urandom);
        req_vl = 4'($urandom); req_masken = 1'($urandom); req_mask = 8'($urandom);
        req_a = rnd256(); req_b = rnd256(); req_s = $urandom; req_old = rnd256();
    endtask

    // Starts from IDLE at #1 after an edge; ends one cycle after the write, idle again.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input bit vs,
                                 input logic [4:0] wa, input logic [3:0] vl, input bit me,
                                 input logic [7:0] mk, input logic [255:0] a,
                                 input logic [255:0] b, input logic [31:0] s,
                                 input logic [255:0] old, input logic [255:0] expVec);
        int lat;
        int expLat;
        bit rdyLow;
        expLat = (vl > 8) ? 8 : int'(vl);
        setFields(op, vs, wa, vl, me, mk, a, b, s, old);
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        scrambleFields();
        lat = 0;
        rdyLow = 1'b1;
        while (!wen_p && lat < 20) begin
            if (req_rdy) rdyLow = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 256'(lat), 256'(expLat));
        checkOutput({tag, " rdy-low-in-exec"}, 256'(rdyLow), 256'(1));
        checkOutput({tag, " waddr"}, 256'(waddr_p), 256'(wa));
        checkOutput({tag, " wvec"}, wvec_p, expVec);
        @(posedge clk); #1;
        checkOutput({tag, " wen-one-cycle"}, 256'(wen_p), 256'(0));
        checkOutput({tag, " idle-busy"}, 256'(busy), 256'(0));
        checkOutput({tag, " wvec-hold"}, wvec_p, expVec);
    endtask

    initial begin
        logic [255:0] a, b, old, expv, expv2;
        logic [31:0]  s;
        logic [2:0]   op;
        logic [3:0]   vl;
        logic [7:0]   mk;
        logic [4:0]   wa;
        bit           vs, me;
        int           t;
        int           seen;

        $display("[TB] start");
        reset = 1'b1;
        req_val = 1'b0;
        setFields(3'd0, 1'b0, 5'd0, 4'd0, 1'b0, 8'd0, '0, '0, '0, '0);
        #3;
        checkOutput("reset wen_p", 256'(wen_p), 256'(0));
        checkOutput("reset waddr_p", 256'(waddr_p), 256'(0));
        checkOutput("reset wvec_p", wvec_p, 256'(0));
        checkOutput("reset busy", 256'(busy), 256'(0));
        checkOutput("reset req_rdy", 256'(req_rdy), 256'(1));
        #9 reset = 1'b0;
        @(posedge clk); #1;

        // Basic ADD: a[i]=i, b[i]=100.
        for (int i = 0; i < 8; i++) begin
            a[32*i +: 32] = 32'(i);
            expv[32*i +: 32] = 32'(100 + i);
        end
        applyStimulus("add", 3'd0, 1'b0, 5'd3, 4'd8, 1'b0, 8'h00, a, splat(32'd100),
                      32'd0, rnd256(), expv);

        // Masked SUB with tail.
        expv = {32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0000000F,
                32'hAAAAAAAA, 32'h0000000F, 32'hAAAAAAAA, 32'h0000000F};
        applyStimulus("msub", 3'd1, 1'b0, 5'd7, 4'd5, 1'b1, 8'b0001_0101, splat(32'h10),
                      splat(32'h1), 32'd0, splat(32'hAAAAAAAA), expv);

        // Scalar shifts.
        applyStimulus("srl", 3'd6, 1'b1, 5'd9, 4'd8, 1'b0, 8'h00, splat(32'h80000000),
                      rnd256(), 32'h24, rnd256(), splat(32'h08000000));
        applyStimulus("sra", 3'd7, 1'b1, 5'd10, 4'd8, 1'b0, 8'h00, splat(32'h80000000),
                      rnd256(), 32'h24, rnd256(), splat(32'hF8000000));

        // Edge vl: 0 writes old back, 12 clamps to 8.
        old = rnd256();
        applyStimulus("vl0", 3'd0, 1'b0, 5'd0, 4'd0, 1'b0, 8'h00, rnd256(), rnd256(),
                      32'd0, old, old);
        a = rnd256(); b = rnd256(); old = rnd256();
        applyStimulus("vl12", 3'd4, 1'b0, 5'd12, 4'd12, 1'b0, 8'h00, a, b, 32'd0, old,
                      refVec(4, 1'b0, 32'd0, a, b, old, 8, 1'b0, 8'h00));

        // Back-to-back vl=2 with req_val held high.
        a = rnd256(); b = rnd256(); old = rnd256();
        expv = refVec(0, 1'b0, 32'd0, a, b, old, 2, 1'b0, 8'h00);
        setFields(3'd0, 1'b0, 5'd17, 4'd2, 1'b0, 8'h00, a, b, 32'd0, old);
        req_val = 1'b1;
        @(posedge clk); #1;
        a = rnd256(); b = rnd256(); old = rnd256();
        expv2 = refVec(2, 1'b0, 32'd0, a, b, old, 2, 1'b0, 8'h00);
        setFields(3'd2, 1'b0, 5'd18, 4'd2, 1'b0, 8'h00, a, b, 32'd0, old);
        t = 0;
        while (!wen_p && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checkOutput("b2b first latency", 256'(t), 256'(2));
        checkOutput("b2b first waddr", 256'(waddr_p), 256'(17));
        checkOutput("b2b first wvec", wvec_p, expv);
        checkOutput("b2b rdy in wb", 256'(req_rdy), 256'(1));
        @(posedge clk); #1;
        req_val = 1'b0;
        scrambleFields();
        t++;
        checkOutput("b2b second busy", 256'(busy), 256'(1));
        while (!wen_p && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        checkOutput("b2b second latency", 256'(t), 256'(5));
        checkOutput("b2b second waddr", 256'(waddr_p), 256'(18));
        checkOutput("b2b second wvec", wvec_p, expv2);
        @(posedge clk); #1;
        checkOutput("b2b idle", 256'(busy), 256'(0));

        // Reset two cycles into a vl=8 op.
        setFields(3'd0, 1'b0, 5'd21, 4'd8, 1'b0, 8'h00, rnd256(), rnd256(), 32'd0, rnd256());
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", 256'(busy), 256'(0));
        checkOutput("midreset wen_p", 256'(wen_p), 256'(0));
        checkOutput("midreset rdy", 256'(req_rdy), 256'(1));
        #2 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (wen_p) seen++;
        end
        checkOutput("midreset no write", 256'(seen), 256'(0));
        a = rnd256(); b = rnd256(); old = rnd256();
        applyStimulus("after reset", 3'd5, 1'b0, 5'd22, 4'd8, 1'b0, 8'h00, a, b, 32'd0, old,
                      refVec(5, 1'b0, 32'd0, a, b, old, 8, 1'b0, 8'h00));

        // Randomized requests against the reference model.
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom); vs = 1'($urandom); wa = 5'($urandom);
            vl = 4'($urandom); me = 1'($urandom); mk = 8'($urandom);
            a = rnd256(); b = rnd256(); s = $urandom; old = rnd256();
            if (n % 3 == 0) s = 32'($urandom_range(0, 31));
            applyStimulus("random", op, vs, wa, vl, me, mk, a, b, s, old,
                          refVec(int'(op), vs, s, a, b, old, int'(vl), me, mk));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
